dma_bus_arbiter: RTL
====================

# dma_bus_arbiter

Sequential four-channel DMA bus arbiter. It collects channel requests, obtains the system bus from the CPU via an HRQ/HLDA handshake, grants one channel at a time with a one-hot DACK, and releases the bus when service ends. It sits between the per-channel DREQ lines and the transfer engine, and supports fixed and rotating priority with a per-grant beat cap for fairness.

## Interface
- NCH, 4: number of channels (design and test at 4)
- MAX_BEATS, 8: beats per grant before forced release; 0 = unlimited
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- dreq  in  NCH  channel requests, level, synchronous to clk
- mask  in  NCH  1 = channel ignored
- rotate  in  1  0 = fixed priority (ch0 highest); 1 = rotating
- hlda  in  1  CPU bus-hold acknowledge, level
- xfer_done  in  1  one-cycle pulse per completed beat of the granted channel
- eop  in  1  one-cycle terminal-count pulse for the granted channel
- hrq  out  1  bus hold request to CPU
- dack  out  NCH  one-hot grant, all zero when idle
- active_ch  out  $clog2(NCH)  index of the granted channel, valid while dack != 0
- busy  out  1  high in any state other than IDLE

## Operation
- Eligible set: dreq & ~mask.
- FSM states IDLE, REQ, GRANT, RELEASE.
  - IDLE → REQ when the eligible set is nonzero.
  - REQ: hrq=1. When hlda=1, pick a winner from the current eligible set and go to GRANT. If the set is empty at that point, go to RELEASE.
  - GRANT: dack[win]=1, active_ch=win. Go to RELEASE on the first of:
    - eop
    - dreq[win]=0
    - mask[win]=1
    - beat count reaches MAX_BEATS (counted on xfer_done)
  - GRANT with hlda=0 (bus revoked): dack clears, go to IDLE, rotation pointer unchanged.
  - RELEASE: hrq=0, dack=0. Go to IDLE when hlda=0.
- Fixed priority: lowest eligible index wins.
- Rotating priority: the search starts at pointer ptr and wraps modulo NCH (ptr=3 searches 3,0,1,2). On GRANT→RELEASE, ptr = win+1 mod NCH, wrapping 3→0. ptr resets to 0 and is kept, but unused, in fixed mode.
- Beat counter: $clog2(MAX_BEATS+1) bits. It clears on entry to GRANT and saturates. xfer_done and eop in the same cycle: eop wins and the beat is counted.
- xfer_done and eop outside GRANT are ignored.
- A change to rotate takes effect at the next winner selection only.
- Reset mid-operation: all outputs drop asynchronously. The CPU must tolerate hrq falling while hlda is high.

## Timing
- Reset values: hrq=0, dack=0, active_ch=0, busy=0, state IDLE, ptr=0, beat count 0.
- All outputs are registered; no combinational input-to-output path.
- dreq sampled eligible at edge N → hrq=1 after edge N+1.
- hlda sampled high at edge M → dack valid after edge M+1.
- Termination condition sampled at edge K → dack=0 and hrq=0 after edge K+1.
- hlda sampled low in RELEASE at edge R → IDLE after R+1. A new hrq occurs no earlier than R+2, so there is one guaranteed idle bus cycle between grants.
- dack is never asserted unless hlda was sampled high in the preceding cycle.
- At most one dack bit is set at any time.

## Structure
- Package dma_pkg holds:
  - state enum (IDLE, REQ, GRANT, RELEASE)
  - NCH constant
  - channel-index type
  - one-hot ↔ index conversion functions
- Sub-module dma_prio_sel: combinational, taking eligible, ptr and rotate and producing valid and win. It is reused by the future channel-register block.
- Top level holds the FSM, ptr register and beat counter.

## Test plan
- Fixed mode, dreq=4'b0110, hlda raised 2 cycles after hrq → dack=4'b0010, then after ch1 drops dreq → dack=4'b0100 on the next tenure.
- Rotating mode, dreq=4'b1111 held, eop after each beat → grant order 0,1,2,3,0 with one idle bus cycle between tenures.
- MAX_BEATS=8, dreq[2] held, xfer_done every cycle → dack=4'b0100 for exactly 8 beats, then release. Re-request yields ch3 if eligible in rotating mode.
- mask=4'b0001 with dreq=4'b0001 → hrq stays 0. Clear mask → hrq=1 the next cycle.
- hlda dropped during GRANT of ch1 → dack=0 next cycle, ptr still 1; next grant in rotating mode goes to ch1.
- rst_n asserted while in GRANT → hrq, dack and busy go to 0 immediately. After release, a fresh request goes through REQ with ptr=0.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA bus arbiter and the channel blocks that use it:
// channel count, channel index/vector types, arbiter FSM state encoding and
// one-hot <-> index conversion helpers.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = $clog2(NCH);

    typedef logic [CH_W-1:0] chan_t;
    typedef logic [NCH-1:0]  chmask_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } dma_state_e;

    // One-hot vector with only bit idx set
    function automatic chmask_t idx2onehot(input chan_t idx);
        chmask_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Index of the set bit of a one-hot vector (highest set bit if not one-hot)
    function automatic chan_t onehot2idx(input chmask_t oh);
        chan_t idx;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (oh[i]) begin
                idx = chan_t'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next channel index, wrapping from NCH-1 back to 0
    function automatic chan_t next_chan(input chan_t idx);
        return chan_t'((int'(idx) + 1) % NCH);
    endfunction

endpackage

// File: rtl/dma_prio_sel.sv
// -----------------------------------------------------------------------------
// dma_prio_sel
// Combinational priority selector. Fixed mode: lowest eligible index wins.
// Rotating mode: the search starts at i_ptr and wraps modulo NCH.
// Ports:
//   i_eligible  eligible channel vector
//   i_ptr       rotation start pointer (ignored in fixed mode)
//   i_rotate    0 = fixed, 1 = rotating
//   o_valid     at least one channel eligible
//   o_win       winning channel index (0 when o_valid = 0)
// -----------------------------------------------------------------------------
module dma_prio_sel
    import dma_pkg::*;
(
    input  chmask_t i_eligible,
    input  chan_t   i_ptr,
    input  logic    i_rotate,
    output logic    o_valid,
    output chan_t   o_win
);

    chan_t w_start;
    chan_t w_idx;

    // Walk channels in search order; the first eligible one encountered wins
    always_comb begin
        o_valid = 1'b0;
        o_win   = '0;
        w_idx   = '0;
        if (i_rotate) begin
            w_start = i_ptr;
        end else begin
            w_start = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            w_idx = chan_t'((int'(w_start) + i) % NCH);
            if (!o_valid && i_eligible[w_idx]) begin
                o_valid = 1'b1;
                o_win   = w_idx;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
// Four-channel DMA bus arbiter. Requests the bus from the CPU (HRQ/HLDA),
// grants one channel at a time with a one-hot DACK, releases on EOP, loss of
// request, masking or a per-grant beat cap. Fixed or rotating priority.
// All inputs pass through one sample register; all outputs are registered.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_dreq, i_mask   channel requests and per-channel masks
//   i_rotate         0 = fixed priority, 1 = rotating
//   i_hlda           CPU hold acknowledge
//   i_xfer_done      beat completed by the granted channel
//   i_eop            terminal count of the granted channel
//   o_hrq            hold request to the CPU
//   o_dack           one-hot grant
//   o_active_ch      granted channel index
//   o_busy           arbiter not idle
// -----------------------------------------------------------------------------
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  chmask_t i_dreq,
    input  chmask_t i_mask,
    input  logic    i_rotate,
    input  logic    i_hlda,
    input  logic    i_xfer_done,
    input  logic    i_eop,
    output logic    o_hrq,
    output chmask_t o_dack,
    output chan_t   o_active_ch,
    output logic    o_busy
);

    // A zero cap still needs a one-bit counter to keep the logic well formed
    localparam int unsigned   BW       = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [BW-1:0] BEAT_CAP = BW'(MAX_BEATS);
    localparam logic [BW-1:0] BEAT_SAT = {BW{1'b1}};

    chmask_t       r_dreq, r_mask;
    logic          r_rotate, r_hlda, r_xfer_done, r_eop;
    dma_state_e    r_state;
    chan_t         r_ptr, r_win;
    logic [BW-1:0] r_beat;
    logic          r_hrq, r_busy;
    chmask_t       r_dack;

    chmask_t       w_elig;
    logic          w_sel_valid;
    chan_t         w_sel_win;
    logic [BW-1:0] w_beat_inc, w_beat_nxt;
    logic          w_cap_hit, w_term;
    dma_state_e    w_state_nxt;
    chan_t         w_ptr_nxt, w_win_nxt;
    logic          w_hrq_nxt, w_busy_nxt;
    chmask_t       w_dack_nxt;

    assign w_elig = r_dreq & ~r_mask;

    dma_prio_sel u_prio_sel (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .i_rotate   (r_rotate),
        .o_valid    (w_sel_valid),
        .o_win      (w_sel_win)
    );

    // Beat count after this cycle's xfer_done, saturating; cap hit when it reaches MAX_BEATS
    always_comb begin
        if (r_xfer_done && (r_beat != BEAT_SAT)) begin
            w_beat_inc = r_beat + {{(BW-1){1'b0}}, 1'b1};
        end else begin
            w_beat_inc = r_beat;
        end
        w_cap_hit = (MAX_BEATS != 32'd0) && (w_beat_inc == BEAT_CAP);
    end

    assign w_term = r_eop | ~r_dreq[r_win] | r_mask[r_win] | w_cap_hit;

    // Input sample stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dreq      <= '0;
            r_mask      <= '0;
            r_rotate    <= 1'b0;
            r_hlda      <= 1'b0;
            r_xfer_done <= 1'b0;
            r_eop       <= 1'b0;
        end else begin
            r_dreq      <= i_dreq;
            r_mask      <= i_mask;
            r_rotate    <= i_rotate;
            r_hlda      <= i_hlda;
            r_xfer_done <= i_xfer_done;
            r_eop       <= i_eop;
        end
    end

    // Next state, pointer, winner and beat count
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (r_hlda) begin
                    if (w_sel_valid) begin
                        w_state_nxt = GRANT;
                        w_win_nxt   = w_sel_win;
                        w_beat_nxt  = '0;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end else begin
                    w_state_nxt = REQ;
                end
            end
            GRANT: begin
                w_beat_nxt = w_beat_inc;
                // Bus revoked: abandon the tenure without advancing the rotation
                if (!r_hlda) begin
                    w_state_nxt = IDLE;
                end else if (w_term) begin
                    w_state_nxt = RELEASE;
                    w_ptr_nxt   = next_chan(r_win);
                end else begin
                    w_state_nxt = GRANT;
                end
            end
            RELEASE: begin
                if (!r_hlda) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RELEASE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so they register together with it
    always_comb begin
        w_hrq_nxt  = (w_state_nxt == REQ) || (w_state_nxt == GRANT);
        w_busy_nxt = (w_state_nxt != IDLE);
        if (w_state_nxt == GRANT) begin
            w_dack_nxt = idx2onehot(w_win_nxt);
        end else begin
            w_dack_nxt = '0;
        end
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_beat  <= '0;
            r_hrq   <= 1'b0;
            r_dack  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_beat  <= w_beat_nxt;
            r_hrq   <= w_hrq_nxt;
            r_dack  <= w_dack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign o_hrq       = r_hrq;
    assign o_dack      = r_dack;
    assign o_active_ch = r_win;
    assign o_busy      = r_busy;

endmodule
